data_bus_arbiter: RTL and testbench
===================================

Name: data_bus_arbiter

Overview:
- Shares the peripheral data bus (data memory, switch controller, LED controller, future devices) between two requesters: m0 = riscv_core load/store port, m1 = a secondary bus master (DMA / UART loader).
- Round-robin arbitration, one outstanding transaction.
- Decodes the device by addr[31:24] and forwards a one-cycle device request.
- Returns read data to the granted master with a one-cycle done pulse.

Parameters:
- NUM_DEV, 3, number of mapped devices; device ids 0..NUM_DEV-1 (0 = data memory, 1 = switches, 2 = LEDs).
- RD_LATENCY, 1, cycles from device request to valid device read data (0 = combinational read).

Ports:
- clk_i  in  1  system clock (sysclk).
- resetn  in  1  synchronous active-low reset.
- m0_req_i  in  1  master 0 request; held until m0_done_o.
- m0_we_i  in  1  master 0 write enable.
- m0_addr_i  in  32  master 0 byte address.
- m0_wd_i  in  32  master 0 write data.
- m0_rd_o  out  32  master 0 read data; valid while m0_done_o=1.
- m0_done_o  out  1  master 0 transaction complete (1-cycle pulse).
- m1_req_i, m1_we_i, m1_addr_i, m1_wd_i, m1_rd_o, m1_done_o: same as m0 for master 1.
- err_o  out  1  unmapped device; pulses together with the done pulse.
- dev_req_o  out  NUM_DEV  one-hot device request (1-cycle pulse).
- dev_we_o  out  1  write enable to devices.
- dev_addr_o  out  32  {8'd0, addr[23:0]} of the latched request.
- dev_wd_o  out  32  latched write data.
- dev_rd_i  in  NUM_DEV*32  device read data; device k at bits [32k+31:32k].

Behaviour:
- Reset (resetn=0 at a clk_i edge), from any state including mid-transaction:
  - state=IDLE; all outputs 0.
  - last_grant=1, so m0 wins the first contention.
  - The interrupted transaction is dropped; no done pulse is issued.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If either req is high, grant one master and go to ISSUE.
  - Only one request: grant that master.
  - Both requests: grant the master != last_grant, then set last_grant to the granted master.
  - On grant, latch the master's we, addr and wd, plus dev_id = addr[31:24].
  - dev_* outputs are driven from the latched copies, so master changes after grant have no effect.
- ISSUE (exactly 1 cycle):
  - If dev_id < NUM_DEV, dev_req_o[dev_id]=1; otherwise dev_req_o=0 and the error flag is set.
  - Write or error: go to DONE.
  - Read with RD_LATENCY=0: capture dev_rd_i[dev_id] this cycle, then go to DONE.
  - Otherwise go to WAIT and load the counter with RD_LATENCY-1.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter = 0, capture dev_rd_i slice dev_id into the read-data register and go to DONE.
- DONE (1 cycle):
  - Granted master's done_o=1 and rd_o = captured data; rd_o=0 for writes and errors.
  - err_o = error flag.
  - Return to IDLE. A request still high in that IDLE cycle is treated as new, so a master must drop req the cycle after done.
- Latency from grant cycle to done pulse:
  - write: 2 cycles;
  - read: 2 + max(RD_LATENCY, 0) cycles, i.e. 3 when RD_LATENCY=1.
- Outputs outside their active state:
  - Non-granted master: done_o=0, rd_o=0.
  - dev_req_o=0 except in ISSUE.
- A new request arriving during ISSUE, WAIT or DONE is only sampled in IDLE; no pre-emption.
- Addresses are forwarded unaligned and unmodified in the low 24 bits; size/alignment is the devices' concern.

Test Plan:
- m0 write addr=0x0200_0004, wd=0x0000_00A5, m1 idle -> dev_req_o=3'b100 for 1 cycle with dev_addr_o=0x0000_0004, dev_we_o=1; m0_done_o 2 cycles after grant; err_o=0.
- m0 read addr=0x0000_0010, RD_LATENCY=1, device 0 returns 0xCAFEF00D the cycle after ISSUE -> m0_rd_o=0xCAFEF00D with m0_done_o 3 cycles after grant; m1_done_o stays 0.
- m0 and m1 both request from reset, each re-requesting after done -> grants alternate m0, m1, m0, m1; no master granted twice in a row while both request.
- m1 read addr=0x0500_0000 (unmapped, NUM_DEV=3) -> dev_req_o stays 0; m1_done_o=1, err_o=1, m1_rd_o=0.
- resetn=0 asserted during WAIT of a read -> next cycle IDLE, all outputs 0, no done pulse; the first contended request after reset is granted to m0.
- m0 changes addr and wd after grant, during ISSUE -> dev_addr_o and dev_wd_o keep the grant-time values.

Source files
------------

// File: rtl/data_bus_arbiter_if.sv
// Shared bus bundle between the two requesters, the arbiter and the mapped devices.
// slave modport: the arbiter's view. master modport: the requester/device side.
interface data_bus_arbiter_if #(
  parameter int unsigned NUM_DEV = 3
);
  logic                     m0_req_i;
  logic                     m0_we_i;
  logic [31:0]              m0_addr_i;
  logic [31:0]              m0_wd_i;
  logic [31:0]              m0_rd_o;
  logic                     m0_done_o;

  logic                     m1_req_i;
  logic                     m1_we_i;
  logic [31:0]              m1_addr_i;
  logic [31:0]              m1_wd_i;
  logic [31:0]              m1_rd_o;
  logic                     m1_done_o;

  logic                     err_o;
  logic [NUM_DEV-1:0]       dev_req_o;
  logic                     dev_we_o;
  logic [31:0]              dev_addr_o;
  logic [31:0]              dev_wd_o;
  logic [NUM_DEV*32-1:0]    dev_rd_i;

  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wd_i,
    output m0_rd_o, m0_done_o,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wd_i,
    output m1_rd_o, m1_done_o,
    output err_o, dev_req_o, dev_we_o, dev_addr_o, dev_wd_o,
    input  dev_rd_i
  );

  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wd_i,
    input  m0_rd_o, m0_done_o,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wd_i,
    input  m1_rd_o, m1_done_o,
    input  err_o, dev_req_o, dev_we_o, dev_addr_o, dev_wd_o,
    output dev_rd_i
  );
endinterface

// File: rtl/data_bus_arbiter.sv
// Two-master round-robin arbiter for the peripheral data bus.
// One transaction in flight; device selected by addr[31:24]; read data and a
// one-cycle done pulse are returned to the granted master.
module data_bus_arbiter #(
  parameter int unsigned NUM_DEV    = 3,
  parameter int unsigned RD_LATENCY = 1
) (
  input logic              clk_i,
  input logic              resetn,
  data_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               grant_q, grant_d;
  logic               we_q, we_d;
  logic [23:0]        addr_q, addr_d;
  logic [31:0]        wd_q, wd_d;
  logic [7:0]         dev_id_q, dev_id_d;
  logic               err_q, err_d;
  logic [31:0]        rd_q, rd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [31:0]        sel_addr;
  logic [31:0]        sel_rd;
  logic               mapped;
  logic               in_done;

  // Device id range check against the number of mapped devices
  always_comb begin
    mapped = ({24'd0, dev_id_q} < NUM_DEV);
  end

  // Read-data slice of the latched device (zero when unmapped)
  always_comb begin
    sel_rd = '0;
    for (int unsigned k = 0; k < NUM_DEV; k++) begin
      if (dev_id_q == 8'(k)) begin
        sel_rd = bus.dev_rd_i[32*k +: 32];
      end
    end
  end

  // State and latched-request registers
  always_ff @(posedge clk_i) begin
    if (!resetn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wd_q         <= '0;
      dev_id_q     <= '0;
      err_q        <= 1'b0;
      rd_q         <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wd_q         <= wd_d;
      dev_id_q     <= dev_id_d;
      err_q        <= err_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state: arbitration in IDLE, device issue, read wait, completion
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wd_d         = wd_q;
    dev_id_d     = dev_id_q;
    err_d        = err_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q;
    sel_addr     = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.m0_req_i || bus.m1_req_i) begin
          // last_grant only moves when both masters contend
          if (bus.m0_req_i && bus.m1_req_i) begin
            grant_d      = ~last_grant_q;
            last_grant_d = ~last_grant_q;
          end else begin
            grant_d = bus.m1_req_i;
          end
          sel_addr = grant_d ? bus.m1_addr_i : bus.m0_addr_i;
          we_d     = grant_d ? bus.m1_we_i   : bus.m0_we_i;
          wd_d     = grant_d ? bus.m1_wd_i   : bus.m0_wd_i;
          addr_d   = sel_addr[23:0];
          dev_id_d = sel_addr[31:24];
          rd_d     = '0;
          err_d    = 1'b0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (!mapped) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (we_q) begin
          state_d = DONE;
        end else if (RD_LATENCY == 0) begin
          rd_d    = sel_rd;
          state_d = DONE;
        end else begin
          cnt_d   = CNT_W'(RD_LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rd_d    = sel_rd;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the state register and latched request
  always_comb begin
    in_done        = (state_q == DONE);
    bus.dev_req_o  = '0;
    for (int unsigned k = 0; k < NUM_DEV; k++) begin
      if ((state_q == ISSUE) && (dev_id_q == 8'(k))) begin
        bus.dev_req_o[k] = 1'b1;
      end
    end
    bus.dev_we_o   = we_q;
    bus.dev_addr_o = {8'd0, addr_q};
    bus.dev_wd_o   = wd_q;
    bus.m0_done_o  = in_done && !grant_q;
    bus.m1_done_o  = in_done &&  grant_q;
    bus.m0_rd_o    = (in_done && !grant_q) ? rd_q : '0;
    bus.m1_rd_o    = (in_done &&  grant_q) ? rd_q : '0;
    bus.err_o      = in_done && err_q;
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: directed vector table, reset/alternation sequences,
// and randomized traffic against a transaction-schedule reference model.
module tb_data_bus_arbiter;

  localparam int unsigned NDEV = 3;
  localparam int unsigned RDL  = 1;
  localparam int          NCYC = 3000;

  logic clk_i = 1'b0;
  logic resetn;

  always #5 clk_i = ~clk_i;

  data_bus_arbiter_if #(.NUM_DEV(NDEV)) bus ();

  data_bus_arbiter #(
    .NUM_DEV    (NDEV),
    .RD_LATENCY (RDL)
  ) dut (
    .clk_i  (clk_i),
    .resetn (resetn),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int               m;
    logic             we;
    logic [31:0]      addr;
    logic [31:0]      wd;
    logic [31:0]      data;
    logic [NDEV-1:0]  exp_req;
    logic             exp_err;
    logic [31:0]      exp_rd;
    int               exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_master(input int m, input logic req, input logic we,
                            input logic [31:0] addr, input logic [31:0] wd);
    if (m == 0) begin
      bus.m0_req_i = req; bus.m0_we_i = we; bus.m0_addr_i = addr; bus.m0_wd_i = wd;
    end else begin
      bus.m1_req_i = req; bus.m1_we_i = we; bus.m1_addr_i = addr; bus.m1_wd_i = wd;
    end
  endtask

  function automatic logic get_done(input int m);
    return (m == 1) ? bus.m1_done_o : bus.m0_done_o;
  endfunction

  function automatic logic [31:0] get_rd(input int m);
    return (m == 1) ? bus.m1_rd_o : bus.m0_rd_o;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, " dev_req"}, 32'(bus.dev_req_o), 32'd0);
    check({tag, " done"}, {30'd0, bus.m1_done_o, bus.m0_done_o}, 32'd0);
    check({tag, " m0_rd"}, bus.m0_rd_o, 32'd0);
    check({tag, " m1_rd"}, bus.m1_rd_o, 32'd0);
    check({tag, " err"}, 32'(bus.err_o), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_idle(tag);
    check({tag, " dev_we"}, 32'(bus.dev_we_o), 32'd0);
    check({tag, " dev_addr"}, bus.dev_addr_o, 32'd0);
    check({tag, " dev_wd"}, bus.dev_wd_o, 32'd0);
  endtask

  task automatic fill_dev(input logic [31:0] val);
    for (int k = 0; k < NDEV; k++) bus.dev_rd_i[32*k +: 32] = val ^ 32'(k);
  endtask

  // One isolated transaction from a single master; master scribbles its
  // inputs right after grant, device data is only valid in the capture cycle.
  task automatic run_vec(input int idx, input vec_t v);
    logic got;
    int   dv;
    string tag;
    tag = $sformatf("vec%0d", idx);
    dv  = int'(v.addr[31:24]);
    set_master(v.m, 1'b1, v.we, v.addr, v.wd);
    set_master(1 - v.m, 1'b0, 1'b0, 32'd0, 32'd0);
    fill_dev(~v.data);
    got = 1'b0;
    for (int c = 1; c <= 8 && !got; c++) begin
      step();
      if (c == 1) begin
        set_master(v.m, 1'b1, ~v.we, ~v.addr, ~v.wd);
        #1;
        check({tag, " issue dev_req"}, 32'(bus.dev_req_o), 32'(v.exp_req));
        check({tag, " issue dev_addr"}, bus.dev_addr_o, {8'd0, v.addr[23:0]});
        check({tag, " issue dev_we"}, 32'(bus.dev_we_o), 32'(v.we));
        check({tag, " issue dev_wd"}, bus.dev_wd_o, v.wd);
      end else begin
        check({tag, " dev_req off"}, 32'(bus.dev_req_o), 32'd0);
      end
      fill_dev(~v.data);
      if (c == 1 + RDL && dv < NDEV) bus.dev_rd_i[32*dv +: 32] = v.data;
      check({tag, " other done"}, 32'(get_done(1 - v.m)), 32'd0);
      if (get_done(v.m)) begin
        got = 1'b1;
        check({tag, " latency"}, 32'(c), 32'(v.exp_lat));
        check({tag, " rd"}, get_rd(v.m), v.exp_rd);
        check({tag, " err"}, 32'(bus.err_o), 32'(v.exp_err));
      end
    end
    if (!got) check({tag, " done timeout"}, 32'd0, 32'd1);
    set_master(v.m, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    check_idle({tag, " idle"});
  endtask

  // Random-phase state
  logic [31:0]     hist [0:NCYC+7][0:NDEV-1];
  logic            rreq [2];
  logic            rwe  [2];
  logic [31:0]     raddr[2];
  logic [31:0]     rwd  [2];
  int              cool [2];
  int              last, win, gnt_c, issue_c, done_c, cap_c, free_c;
  logic [7:0]      xdev;
  logic            xwe, xerr;
  logic [31:0]     xaddr, xwd, xrd;
  logic [NDEV-1:0] xreq;
  logic            d0, d1;

  function automatic logic [7:0] rand_dev();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 7) return 8'(r % 3);
    else if (r == 7) return 8'd3;
    else if (r == 8) return 8'hFF;
    else return 8'd5;
  endfunction

  initial begin
    int order_ok;
    logic got;
    int w;

    vecs[0] = '{0, 1'b1, 32'h0200_0004, 32'h0000_00A5, 32'h0, 3'b100, 1'b0, 32'h0, 2};
    vecs[1] = '{0, 1'b0, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 3'b001, 1'b0, 32'hCAFE_F00D, 3};
    vecs[2] = '{1, 1'b0, 32'h0100_0003, 32'h0, 32'h1234_5678, 3'b010, 1'b0, 32'h1234_5678, 3};
    vecs[3] = '{1, 1'b1, 32'h0012_3456, 32'hDEAD_BEEF, 32'h0, 3'b001, 1'b0, 32'h0, 2};
    vecs[4] = '{1, 1'b0, 32'h0500_0000, 32'h0, 32'h5A5A_5A5A, 3'b000, 1'b1, 32'h0, 2};
    vecs[5] = '{0, 1'b1, 32'hFF00_0000, 32'h1111_2222, 32'h0, 3'b000, 1'b1, 32'h0, 2};
    vecs[6] = '{0, 1'b0, 32'h02AB_CDEF, 32'h0, 32'h0BAD_CAFE, 3'b100, 1'b0, 32'h0BAD_CAFE, 3};
    vecs[7] = '{0, 1'b0, 32'h0300_0000, 32'h0, 32'h7777_7777, 3'b000, 1'b1, 32'h0, 2};

    resetn = 1'b0;
    set_master(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_master(1, 1'b0, 1'b0, 32'd0, 32'd0);
    fill_dev(32'd0);
    repeat (3) step();
    check_reset_outputs("reset");
    resetn = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a read's WAIT cycle drops the transaction
    set_master(0, 1'b1, 1'b0, 32'h0000_0020, 32'd0);
    fill_dev(32'h5555_5555);
    step();
    step();
    check("midrst txn dev_addr", bus.dev_addr_o, 32'h0000_0020);
    check("midrst no early done", 32'(bus.m0_done_o), 32'd0);
    resetn = 1'b0;
    step();
    check_reset_outputs("midrst");
    resetn = 1'b1;
    set_master(0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("midrst no done", {30'd0, bus.m1_done_o, bus.m0_done_o}, 32'd0);
    end

    // Both masters request from reset and re-request after each done
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    set_master(0, 1'b1, 1'b1, 32'h0000_0100, 32'hA0A0_A0A0);
    set_master(1, 1'b1, 1'b1, 32'h0100_0200, 32'hB1B1_B1B1);
    for (int t = 0; t < 4; t++) begin
      got = 1'b0;
      w = 0;
      for (int n = 0; n < 10 && !got; n++) begin
        step();
        check("alt both done", 32'(bus.m0_done_o & bus.m1_done_o), 32'd0);
        if (bus.m0_done_o || bus.m1_done_o) begin
          got = 1'b1;
          w = bus.m1_done_o ? 1 : 0;
        end
      end
      if (!got) check("alt done timeout", 32'd0, 32'd1);
      else check($sformatf("alt grant order %0d", t), 32'(w), 32'(t % 2));
      set_master(w, 1'b0, 1'b1, 32'd0, 32'd0);
      step();
      check("alt idle done", {30'd0, bus.m1_done_o, bus.m0_done_o}, 32'd0);
      set_master(w, 1'b1, 1'b1, (w == 1) ? 32'h0100_0200 : 32'h0000_0100, 32'h0);
    end
    set_master(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_master(1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (4) step();

    // Randomized traffic: the model schedules issue/done cycles from the grant
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    last = 1; win = 0; gnt_c = -10; issue_c = -10; done_c = -10; cap_c = 0; free_c = 0;
    xdev = '0; xwe = 1'b0; xerr = 1'b0; xaddr = '0; xwd = '0; xreq = '0;
    for (int m = 0; m < 2; m++) begin
      rreq[m] = 1'b0; rwe[m] = 1'b0; raddr[m] = '0; rwd[m] = '0; cool[m] = 0;
    end
    for (int c = 0; c < NCYC; c++) begin
      d0  = (c == done_c) && (win == 0);
      d1  = (c == done_c) && (win == 1);
      xrd = '0;
      if (c == done_c && !xwe && !xerr) xrd = hist[cap_c][int'(xdev)];
      check("rnd dev_req", 32'(bus.dev_req_o), (c == issue_c) ? 32'(xreq) : 32'd0);
      if (c == issue_c) begin
        check("rnd dev_addr", bus.dev_addr_o, {8'd0, xaddr[23:0]});
        check("rnd dev_we", 32'(bus.dev_we_o), 32'(xwe));
        check("rnd dev_wd", bus.dev_wd_o, xwd);
      end
      check("rnd m0_done", 32'(bus.m0_done_o), 32'(d0));
      check("rnd m1_done", 32'(bus.m1_done_o), 32'(d1));
      check("rnd m0_rd", bus.m0_rd_o, d0 ? xrd : 32'd0);
      check("rnd m1_rd", bus.m1_rd_o, d1 ? xrd : 32'd0);
      check("rnd err", 32'(bus.err_o), (c == done_c) ? 32'(xerr) : 32'd0);

      if (c == done_c) begin
        rreq[win] = 1'b0;
        cool[win] = c + 2;
      end
      for (int m = 0; m < 2; m++) begin
        if (!rreq[m] && c >= cool[m] && $urandom_range(0, 3) == 0) begin
          rreq[m]  = 1'b1;
          rwe[m]   = 1'($urandom_range(0, 1));
          raddr[m] = {rand_dev(), 24'($urandom)};
          rwd[m]   = $urandom;
        end else if (rreq[m] && m == win && c > gnt_c && c < done_c) begin
          raddr[m] = $urandom;
          rwd[m]   = $urandom;
          rwe[m]   = 1'($urandom_range(0, 1));
        end
        set_master(m, rreq[m], rwe[m], raddr[m], rwd[m]);
      end
      for (int k = 0; k < NDEV; k++) begin
        hist[c][k] = $urandom;
        bus.dev_rd_i[32*k +: 32] = hist[c][k];
      end

      if (c >= free_c && (rreq[0] || rreq[1])) begin
        if (rreq[0] && rreq[1]) begin
          win  = 1 - last;
          last = win;
        end else begin
          win = rreq[1] ? 1 : 0;
        end
        gnt_c   = c;
        xwe     = rwe[win];
        xaddr   = raddr[win];
        xwd     = rwd[win];
        xdev    = xaddr[31:24];
        xerr    = (int'(xdev) >= NDEV);
        xreq    = xerr ? '0 : (NDEV'(1) << xdev);
        issue_c = c + 1;
        cap_c   = c + 1 + RDL;
        done_c  = (xwe || xerr) ? c + 2 : c + 2 + RDL;
        free_c  = done_c + 1;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
